// File: rtl/ball_motion.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | ball_motion : brick-breaker ball engine (step timing, wall/paddle/brick     |
// |               bounce, brick hit pulse, lost-ball flag)                      |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module ball_motion #(
    parameter int COORD_W   = 10,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int BALL_SIZE = 20,
    parameter int BRICK_W   = 58,
    parameter int BRICK_H   = 20,
    parameter int PADDLE_W  = 80,
    parameter int PADDLE_Y  = 440,
    parameter int INIT_X    = 310,
    parameter int INIT_Y    = 300,
    parameter int SPEED     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               launch,
    input  logic [24:0]        delay_done,
    input  logic [COORD_W-1:0] paddle_x,
    input  logic [COORD_W-1:0] brick_x,
    input  logic [COORD_W-1:0] brick_y,
    input  logic               brick_exist,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               dir_x,
    output logic               dir_y,
    output logic               hit_brick,
    output logic               ball_lost
);

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   wide_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_CHECK = 3'd2,
        S_MOVE  = 3'd3,
        S_LOST  = 3'd4
    } state_t;

    localparam coord_t c_step       = coord_t'(SPEED);
    localparam coord_t c_init_x     = coord_t'(INIT_X);
    localparam coord_t c_init_y     = coord_t'(INIT_Y);
    localparam wide_t  c_ball       = wide_t'(BALL_SIZE);
    localparam wide_t  c_speed      = wide_t'(SPEED);
    localparam wide_t  c_screen_w   = wide_t'(SCREEN_W);
    localparam wide_t  c_screen_h   = wide_t'(SCREEN_H);
    localparam wide_t  c_brick_w_m1 = wide_t'(BRICK_W - 1);
    localparam wide_t  c_brick_h_m1 = wide_t'(BRICK_H - 1);
    localparam wide_t  c_paddle_wm1 = wide_t'(PADDLE_W - 1);
    localparam wide_t  c_paddle_y   = wide_t'(PADDLE_Y);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [24:0] r_cnt;
    logic [24:0] w_cnt_nxt;
    logic        r_in_brick;
    logic        w_in_brick_nxt;
    coord_t      w_x_nxt;
    coord_t      w_y_nxt;
    logic        w_dir_x_nxt;
    logic        w_dir_y_nxt;
    logic        w_hit_nxt;
    logic        w_lost_nxt;

    // One extra bit so edge sums never wrap before comparison.
    wide_t w_bx;
    wide_t w_by;
    wide_t w_px;
    wide_t w_kx;
    wide_t w_ky;

    logic w_brick_ov;
    logic w_paddle_ov;
    logic w_hit_right;
    logic w_hit_left;
    logic w_fall;
    logic w_top;

    assign w_bx = {1'b0, ball_x};
    assign w_by = {1'b0, ball_y};
    assign w_px = {1'b0, paddle_x};
    assign w_kx = {1'b0, brick_x};
    assign w_ky = {1'b0, brick_y};

    assign w_brick_ov  = brick_exist
                       && (w_bx <= w_kx + c_brick_w_m1)
                       && (w_bx + c_ball >= w_kx)
                       && (w_by <= w_ky + c_brick_h_m1)
                       && (w_by + c_ball >= w_ky);

    assign w_paddle_ov = dir_y
                       && (w_by < c_paddle_y)
                       && (w_by + c_ball >= c_paddle_y)
                       && (w_bx + c_ball >= w_px)
                       && (w_bx <= w_px + c_paddle_wm1);

    assign w_hit_right = dir_x  && (w_bx + c_ball + c_speed > c_screen_w);
    assign w_hit_left  = !dir_x && (w_bx < c_speed);
    assign w_fall      = dir_y  && (w_by + c_ball + c_speed > c_screen_h);
    assign w_top       = !dir_y && (w_by < c_speed);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_in_brick <= 1'b0;
            ball_x     <= c_init_x;
            ball_y     <= c_init_y;
            dir_x      <= 1'b1;
            dir_y      <= 1'b0;
            hit_brick  <= 1'b0;
            ball_lost  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_in_brick <= w_in_brick_nxt;
            ball_x     <= w_x_nxt;
            ball_y     <= w_y_nxt;
            dir_x      <= w_dir_x_nxt;
            dir_y      <= w_dir_y_nxt;
            hit_brick  <= w_hit_nxt;
            ball_lost  <= w_lost_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_in_brick_nxt = r_in_brick;
        w_x_nxt        = ball_x;
        w_y_nxt        = ball_y;
        w_dir_x_nxt    = dir_x;
        w_dir_y_nxt    = dir_y;
        w_hit_nxt      = 1'b0;
        w_lost_nxt     = ball_lost;

        case (r_state)
            S_IDLE: begin
                if (launch) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt >= delay_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_CHECK;
                end else begin
                    w_cnt_nxt = r_cnt + 25'd1;
                end
            end
            S_CHECK: begin
                w_state_nxt    = S_MOVE;
                w_in_brick_nxt = w_brick_ov ? r_in_brick : 1'b0;
                if (w_hit_right) begin
                    w_dir_x_nxt = 1'b0;
                end else if (w_hit_left) begin
                    w_dir_x_nxt = 1'b1;
                end
                // Paddle wins over the floor; a lost ball keeps its last motion.
                if (w_paddle_ov) begin
                    w_dir_y_nxt = 1'b0;
                end else if (w_fall) begin
                    w_state_nxt = S_LOST;
                    w_lost_nxt  = 1'b1;
                    w_dir_x_nxt = dir_x;
                end else if (w_brick_ov && !r_in_brick) begin
                    w_dir_y_nxt    = ~dir_y;
                    w_hit_nxt      = 1'b1;
                    w_in_brick_nxt = 1'b1;
                end else if (w_top) begin
                    w_dir_y_nxt = 1'b1;
                end
            end
            S_MOVE: begin
                w_state_nxt = S_WAIT;
                w_x_nxt     = dir_x ? ball_x + c_step : ball_x - c_step;
                w_y_nxt     = dir_y ? ball_y + c_step : ball_y - c_step;
            end
            S_LOST: begin
                if (launch) begin
                    w_state_nxt = S_IDLE;
                    w_x_nxt     = c_init_x;
                    w_y_nxt     = c_init_y;
                    w_dir_x_nxt = 1'b1;
                    w_dir_y_nxt = 1'b0;
                    w_lost_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ball_motion.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_ball_motion : directed bench for the ball engine                         |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_ball_motion;

    logic        clk;
    logic        rst;
    logic        launch;
    logic [24:0] delay_done;
    logic [9:0]  paddle_x;
    logic [9:0]  brick_x;
    logic [9:0]  brick_y;
    logic        brick_exist;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic        dir_x;
    logic        dir_y;
    logic        hit_brick;
    logic        ball_lost;

    int checks   = 0;
    int failures = 0;
    int at       = 0;

    ball_motion dut (
        .clk         (clk),
        .rst         (rst),
        .launch      (launch),
        .delay_done  (delay_done),
        .paddle_x    (paddle_x),
        .brick_x     (brick_x),
        .brick_y     (brick_y),
        .brick_exist (brick_exist),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .dir_x       (dir_x),
        .dir_y       (dir_y),
        .hit_brick   (hit_brick),
        .ball_lost   (ball_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(ball_x), 32'(x));
        chk({tag, "_y"}, 32'(ball_y), 32'(y));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk_pos(tag, 310, 300);
        chk({tag, "_dx"},   32'(dir_x),     32'd1);
        chk({tag, "_dy"},   32'(dir_y),     32'd0);
        chk({tag, "_hit"},  32'(hit_brick), 32'd0);
        chk({tag, "_lost"}, 32'(ball_lost), 32'd0);
    endtask

    // Advance n rising edges and sample 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Move to the sample point just after landing edge of step k (3 cycles/step).
    task automatic goto_step(input int k);
        tick(3 * (k - at));
        at = k;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        launch      = 1'b0;
        delay_done  = 25'd0;
        paddle_x    = 10'd200;
        brick_x     = 10'd0;
        brick_y     = 10'd0;
        brick_exist = 1'b0;

        tick(2);
        chk_reset_outs("reset");
        rst = 1'b0;
        tick(4);
        chk_pos("idle_hold", 310, 300);

        // Launch, delay 0: first move 3 edges later, then every 3 cycles.
        launch = 1'b1;
        tick(1);
        launch = 1'b0;
        at = 0;
        goto_step(1);
        chk_pos("step1", 311, 299);
        chk("step1_dx", 32'(dir_x), 32'd1);
        chk("step1_dy", 32'(dir_y), 32'd0);
        tick(2);
        chk_pos("step1_hold", 311, 299);
        tick(1); at = 2;
        chk_pos("step2", 312, 298);

        // Top wall.
        goto_step(300);
        chk_pos("top_arrive", 610, 0);
        tick(2);
        chk("top_dy", 32'(dir_y), 32'd1);
        chk("top_y_hold", 32'(ball_y), 32'd0);
        tick(1); at = 301;
        chk_pos("top_after", 611, 1);

        // Right wall.
        goto_step(309);
        chk_pos("right_619", 619, 9);
        goto_step(310);
        chk_pos("right_620", 620, 10);
        chk("right_dx_pre", 32'(dir_x), 32'd1);
        tick(2);
        chk("right_dx", 32'(dir_x), 32'd0);
        tick(1); at = 311;
        chk_pos("right_after", 619, 11);

        // Paddle bounce at y=420, paddle left edge 200.
        goto_step(720);
        chk_pos("paddle_arrive", 210, 420);
        chk("paddle_dy_pre", 32'(dir_y), 32'd1);
        tick(2);
        chk("paddle_dy", 32'(dir_y), 32'd0);
        tick(1); at = 721;
        chk_pos("paddle_after", 209, 419);
        paddle_x = 10'd0;

        // Left wall.
        goto_step(930);
        chk_pos("left_arrive", 0, 210);
        tick(2);
        chk("left_dx", 32'(dir_x), 32'd1);
        tick(1); at = 931;
        chk_pos("left_after", 1, 209);

        goto_step(1140);
        chk_pos("top2", 210, 0);

        // Paddle missed: floor reached at y=460, ball lost and frozen.
        goto_step(1600);
        chk_pos("lost_arrive", 570, 460);
        chk("lost_pre", 32'(ball_lost), 32'd0);
        tick(2);
        chk("lost_flag", 32'(ball_lost), 32'd1);
        chk_pos("lost_pos", 570, 460);
        tick(6);
        chk("lost_hold", 32'(ball_lost), 32'd1);
        chk_pos("lost_frozen", 570, 460);

        launch = 1'b1;
        tick(1);
        launch = 1'b0;
        chk_reset_outs("rearm");
        tick(3);
        chk_pos("rearm_idle", 310, 300);

        // Relaunch; brick kicks shift the diagonal so the ball meets the corner.
        brick_x = 10'd320;
        brick_y = 10'd290;
        launch  = 1'b1;
        tick(1);
        launch  = 1'b0;
        at = 0;
        goto_step(10);
        chk_pos("brick_arrive", 320, 290);
        brick_exist = 1'b1;
        tick(2);
        chk("brick_dy", 32'(dir_y), 32'd1);
        chk("brick_hit", 32'(hit_brick), 32'd1);
        tick(1); at = 11;
        chk_pos("brick_after", 321, 291);
        chk("brick_hit_end", 32'(hit_brick), 32'd0);
        for (int i = 0; i < 9; i++) begin
            tick(1);
            chk("brick_no_repulse", 32'(hit_brick), 32'd0);
        end
        at = 14;
        chk_pos("brick_inside", 324, 294);
        chk("brick_no_rebounce", 32'(dir_y), 32'd1);
        brick_exist = 1'b0;
        goto_step(15);
        chk_pos("kick_arrive", 325, 295);
        brick_exist = 1'b1;
        tick(2);
        chk("kick_dy", 32'(dir_y), 32'd0);
        chk("kick_hit", 32'(hit_brick), 32'd1);
        brick_exist = 1'b0;
        tick(1); at = 16;
        chk_pos("kick_after", 326, 294);

        // Corner: both directions flip in one check.
        goto_step(310);
        chk_pos("corner_arrive", 620, 0);
        tick(2);
        chk("corner_dx", 32'(dir_x), 32'd0);
        chk("corner_dy", 32'(dir_y), 32'd1);
        tick(1); at = 311;
        chk_pos("corner_after", 619, 1);

        // Asynchronous reset mid-WAIT, then an 8-cycle step with delay 5.
        delay_done = 25'd5;
        tick(3);
        chk_pos("wait_mid", 619, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outs("async_rst");
        #1;
        rst = 1'b0;
        tick(1);
        chk_reset_outs("post_rst");
        launch = 1'b1;
        tick(1);
        launch = 1'b0;
        tick(6);
        chk_pos("d5_hold6", 310, 300);
        tick(1);
        chk_pos("d5_hold7", 310, 300);
        tick(1);
        chk_pos("d5_step1", 311, 299);
        tick(7);
        chk_pos("d5_hold15", 311, 299);
        tick(1);
        chk_pos("d5_step2", 312, 298);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
